// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and its round-robin picker.
//   - arb_state_e      : arbiter FSM state encoding
//   - DefaultDataWidth : byte width shared with the UART top-level transmitter
//   - idx_width()      : index width for an N-entry vector (never below 1)
package uart_tx_arbiter_pkg;

    localparam int unsigned DefaultDataWidth = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWaitHi = 2'd2,
        StWaitLo = 2'd3
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus between NUM_REQ byte sources, the arbiter and the UART transmitter.
//   req_valid/req_data/req_last/req_ready : per-source valid/ready byte stream
//   tx_enable/tx_data/tx_busy             : UART Tx launch port
//   grant_valid/grant_id/tx_timeout       : arbiter status
// slave  = arbiter side, master = sources plus Tx side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = uart_tx_arbiter_pkg::DefaultDataWidth,
    localparam int unsigned IdW       = uart_tx_arbiter_pkg::idx_width(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_enable;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_busy;
    logic                          grant_valid;
    logic [IdW-1:0]                grant_id;
    logic                          tx_timeout;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_enable, tx_data, grant_valid, grant_id, tx_timeout
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_enable, tx_data, grant_valid, grant_id, tx_timeout
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   valid   : request vector
//   rr_ptr  : highest-priority index for this round
//   lock    : when set, only lock_id may be chosen
//   lock_id : owner index while locked
//   pick    : chosen index
//   found   : a valid candidate exists
module uart_rr_pick import uart_tx_arbiter_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IdW-1:0]     rr_ptr,
    input  logic               lock,
    input  logic [IdW-1:0]     lock_id,
    output logic [IdW-1:0]     pick,
    output logic               found
);

    int             idx;
    logic [IdW-1:0] cand;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        if (lock) begin
            pick  = lock_id;
            found = valid[lock_id];
        end else begin
            // Scan from the farthest offset down so the nearest valid index to rr_ptr wins.
            for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= int'(NUM_REQ)) begin
                    idx = idx - int'(NUM_REQ);
                end
                cand = IdW'(idx);
                if (valid[cand]) begin
                    pick  = cand;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of uart_tx_arbiter_if (source handshakes, Tx port, status)
// One Tx frame per accepted byte; with LOCK_ENABLE the grant stays on one source
// until its req_last byte has been sent.
module uart_tx_arbiter import uart_tx_arbiter_pkg::*; #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
    parameter int unsigned LOCK_ENABLE  = 1,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input logic             clk,
    input logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned IdW  = idx_width(NUM_REQ);
    localparam int unsigned CntW = idx_width(BUSY_TIMEOUT) + 1;

    arb_state_e            state_q;
    logic [IdW-1:0]        rr_ptr_q;
    logic                  locked_q;
    logic                  last_q;
    logic [CntW-1:0]       cnt_q;
    logic                  tx_enable_q;
    logic                  tx_timeout_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  grant_valid_q;
    logic [IdW-1:0]        grant_id_q;

    logic [IdW-1:0]        pick;
    logic                  found;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic [NUM_REQ-1:0]    ready_vec;
    logic [IdW-1:0]        next_ptr;
    logic                  rotate;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid   (bus.req_valid),
        .rr_ptr  (rr_ptr_q),
        .lock    (locked_q),
        .lock_id (grant_id_q),
        .pick    (pick),
        .found   (found)
    );

    // Never accept while the transmitter is still draining a frame.
    assign accept = (state_q == StIdle) && !bus.tx_busy && found;

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        ready_vec = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick == IdW'(i)) begin
                sel_data     = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last     = bus.req_last[i];
                ready_vec[i] = accept;
            end
        end
    end

    assign next_ptr = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    // Rotation (and unlock) only after a packet's last byte, or every byte without lock.
    assign rotate   = last_q || (LOCK_ENABLE == 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            locked_q      <= 1'b0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            tx_enable_q   <= 1'b0;
            tx_timeout_q  <= 1'b0;
            tx_data_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            tx_enable_q  <= 1'b0;
            tx_timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tx_data_q     <= sel_data;
                        grant_id_q    <= pick;
                        grant_valid_q <= 1'b1;
                        last_q        <= sel_last;
                        if ((LOCK_ENABLE != 0) && !sel_last) begin
                            locked_q <= 1'b1;
                        end
                        tx_enable_q   <= 1'b1;
                        state_q       <= StLaunch;
                    end
                end
                StLaunch: begin
                    cnt_q   <= '0;
                    state_q <= StWaitHi;
                end
                StWaitHi: begin
                    if (bus.tx_busy) begin
                        state_q <= StWaitLo;
                    end else if (cnt_q == CntW'(BUSY_TIMEOUT - 2)) begin
                        // Count reaches BUSY_TIMEOUT-1 this cycle: drop the byte.
                        tx_timeout_q  <= 1'b1;
                        grant_valid_q <= 1'b0;
                        state_q       <= StIdle;
                        if (rotate) begin
                            locked_q <= 1'b0;
                            rr_ptr_q <= next_ptr;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitLo: begin
                    if (!bus.tx_busy) begin
                        grant_valid_q <= 1'b0;
                        state_q       <= StIdle;
                        if (rotate) begin
                            locked_q <= 1'b0;
                            rr_ptr_q <= next_ptr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready   = ready_vec;
    assign bus.tx_enable   = tx_enable_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.tx_timeout  = tx_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: tests push expected (grant_id, byte)
// pairs, a negedge monitor pops one per tx_enable and compares.
module tb_uart_tx_arbiter;

    localparam int unsigned NReq    = 4;
    localparam int unsigned Dw      = 8;
    localparam int unsigned Bt      = 16;
    localparam int unsigned BusyLen = 10;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NReq), .DATA_WIDTH(Dw)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NReq),
        .DATA_WIDTH   (Dw),
        .LOCK_ENABLE  (1),
        .BUSY_TIMEOUT (Bt)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    exp_t  exp_q[$];
    beat_t src_q[NReq][$];
    int    hs_cnt[NReq];
    int    en_cnt = 0;
    int    to_cnt = 0;
    int    last_hs_cyc = -100;
    int    last_en_cyc = -100;
    logic  model_busy = 1'b0;
    logic  busy_force = 1'b0;
    logic  silent = 1'b0;

    assign bus.tx_busy = model_busy | busy_force;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic load(input int i, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[i].push_back(b);
    endtask

    task automatic expect_byte(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic int src_pending();
        int n = 0;
        for (int i = 0; i < int'(NReq); i++) n += src_q[i].size();
        return n;
    endfunction

    function automatic int hs_total();
        int n = 0;
        for (int i = 0; i < int'(NReq); i++) n += hs_cnt[i];
        return n;
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && src_pending() == 0 && !bus.grant_valid &&
                     !bus.tx_busy) && n < 3000);
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got pending=%0d expected 0", name, exp_q.size());
        end
    endtask

    // Tx model: busy rises one cycle after enable and stays high BusyLen cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_enable && !silent) begin
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (BusyLen) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Sources: present queue heads, pop after an observed handshake.
    initial begin
        logic [NReq-1:0] hs;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready & {NReq{!reset}};
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(NReq); i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_data[i*Dw +: Dw] = src_q[i][0].data;
                    bus.req_last[i]          = src_q[i][0].last;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor.
    initial begin
        exp_t e;
        for (int i = 0; i < int'(NReq); i++) hs_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.req_ready != '0) begin
                    check("ready_onehot", $countones(bus.req_ready), 1);
                    check("ready_while_busy", int'(bus.tx_busy), 0);
                end
                for (int i = 0; i < int'(NReq); i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        hs_cnt[i]++;
                        last_hs_cyc = cyc;
                    end
                end
                if (bus.tx_enable) begin
                    en_cnt++;
                    check("launch_latency", cyc - last_hs_cyc, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_launch: got id %0d data %0h expected none",
                                 bus.grant_id, bus.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_id", int'(bus.grant_id), int'(e.id));
                        check("tx_data", int'(bus.tx_data), int'(e.data));
                        check("grant_valid_launch", int'(bus.grant_valid), 1);
                    end
                    last_en_cyc = cyc;
                end
                if (bus.tx_timeout) begin
                    to_cnt++;
                    check("timeout_expected", int'(silent), 1);
                    check("timeout_delay", cyc - last_en_cyc, int'(Bt));
                    check("timeout_grant_valid", int'(bus.grant_valid), 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en0;
        int hs0;
        int to0;
        int n;

        // Reset values.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_tx_enable", int'(bus.tx_enable), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_grant_valid", int'(bus.grant_valid), 0);
        check("rst_grant_id", int'(bus.grant_id), 0);
        check("rst_tx_timeout", int'(bus.tx_timeout), 0);

        // Single byte from source 0.
        en0 = en_cnt;
        hs0 = hs_cnt[0];
        expect_byte(0, 8'hA5);
        load(0, 8'hA5, 1'b1);
        drain("single");
        check("single_enables", en_cnt - en0, 1);
        check("single_ready_cycles", hs_cnt[0] - hs0, 1);

        // Fairness: all four sources, two single-byte packets each.
        apply_reset();
        @(negedge clk);
        en0 = en_cnt;
        load(0, 8'h10, 1'b1); load(0, 8'h14, 1'b1);
        load(1, 8'h21, 1'b1); load(1, 8'h25, 1'b1);
        load(2, 8'h32, 1'b1); load(2, 8'h36, 1'b1);
        load(3, 8'h43, 1'b1); load(3, 8'h47, 1'b1);
        expect_byte(0, 8'h10); expect_byte(1, 8'h21);
        expect_byte(2, 8'h32); expect_byte(3, 8'h43);
        expect_byte(0, 8'h14); expect_byte(1, 8'h25);
        expect_byte(2, 8'h36); expect_byte(3, 8'h47);
        drain("fair");
        check("fair_enables", en_cnt - en0, 8);

        // Packet lock: rr_ptr moved to 1 first, then source 1 sends a 3-byte packet.
        apply_reset();
        @(negedge clk);
        load(0, 8'h0A, 1'b1);
        expect_byte(0, 8'h0A);
        drain("lock_pre");
        load(1, 8'h11, 1'b0); load(1, 8'h22, 1'b0); load(1, 8'h33, 1'b1);
        load(0, 8'h0B, 1'b1);
        load(2, 8'h2C, 1'b1);
        expect_byte(1, 8'h11); expect_byte(1, 8'h22); expect_byte(1, 8'h33);
        expect_byte(2, 8'h2C); expect_byte(0, 8'h0B);
        drain("lock");

        // Timeout: Tx never raises busy; rr_ptr is 1 here.
        silent = 1'b1;
        to0 = to_cnt;
        load(1, 8'h5A, 1'b1); load(1, 8'h5B, 1'b1);
        load(2, 8'h6B, 1'b1);
        expect_byte(1, 8'h5A); expect_byte(2, 8'h6B); expect_byte(1, 8'h5B);
        drain("timeout");
        check("timeout_count", to_cnt - to0, 3);
        silent = 1'b0;

        // Busy at idle, then reset during WAIT_LO; rr_ptr is 2 here.
        @(posedge clk);
        #1 busy_force = 1'b1;
        hs0 = hs_total();
        load(0, 8'hC0, 1'b1); load(1, 8'hC1, 1'b1);
        load(2, 8'hC2, 1'b1); load(3, 8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        check("busy_ready", int'(bus.req_ready), 0);
        check("busy_no_handshake", hs_total() - hs0, 0);
        expect_byte(2, 8'hC2);
        en0 = en_cnt;
        @(posedge clk);
        #1 busy_force = 1'b0;
        n = 0;
        while (en_cnt == en0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_release_launch", en_cnt - en0, 1);
        n = 0;
        while (!model_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("wait_lo_grant_valid", int'(bus.grant_valid), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        expect_byte(0, 8'hC0); expect_byte(1, 8'hC1); expect_byte(3, 8'hC3);
        @(posedge clk);
        @(negedge clk);
        check("midrst_grant_valid", int'(bus.grant_valid), 0);
        check("midrst_tx_enable", int'(bus.tx_enable), 0);
        check("midrst_grant_id", int'(bus.grant_id), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        drain("post_reset");
        check("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter (Tx_top: enable / i_data / o_busy) among NUM_REQ byte sources.
- Each source uses a valid/ready handshake. The block launches one Tx frame per accepted byte and waits for the frame to finish.
- Optional packet lock keeps the grant on one source until its last byte.
- Sits between on-chip producers and the UART top-level transmitter port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, byte width; must equal the UART INPUT_DATA_WIDTH.
- LOCK_ENABLE, 1, 1 = hold grant from first byte until req_last beat; 0 = rotate every byte.
- BUSY_TIMEOUT, 16, cycles allowed after tx_enable for tx_busy to rise before the byte is declared lost (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-source byte valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-source byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  per-source last-byte-of-packet flag.
- req_ready  out  NUM_REQ  per-source accept strobe; a transfer occurs when valid&ready.
- tx_enable  out  1  one-cycle launch pulse to Tx enable.
- tx_data  out  DATA_WIDTH  byte to Tx i_data; held stable from launch until return to IDLE.
- tx_busy  in  1  Tx o_busy.
- grant_valid  out  1  a byte from grant_id is in flight.
- grant_id  out  clog2(NUM_REQ)  current or most recent owner.
- tx_timeout  out  1  one-cycle pulse: tx_busy never rose within BUSY_TIMEOUT.

Behaviour:
- Reset values:
  - tx_enable=0, tx_data=0, req_ready=0, grant_valid=0, grant_id=0, tx_timeout=0.
  - state=IDLE, rr_ptr=0, locked=0, timeout counter=0.
- States: IDLE, LAUNCH, WAIT_HI, WAIT_LO.
- Selection (combinational, in IDLE):
  - If locked, the candidate is grant_id only.
  - Otherwise the candidate is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- req_ready[i]=1 only when state==IDLE && tx_busy==0 && i==candidate && req_valid[i]. At most one bit is high. req_ready is combinational from state and inputs.
- IDLE -> LAUNCH on handshake. On that edge:
  - tx_data <= selected byte; grant_id <= i; grant_valid <= 1.
  - Latch req_last[i] into last_q.
  - If LOCK_ENABLE && !req_last[i], set locked=1.
- LAUNCH: tx_enable=1 for exactly this cycle. Next state is WAIT_HI and the counter clears.
- WAIT_HI:
  - tx_busy=1 -> WAIT_LO.
  - Otherwise the counter increments. At count BUSY_TIMEOUT-1: pulse tx_timeout for one cycle, go to IDLE, grant_valid <= 0.
  - On timeout the byte is dropped and not retried. rr_ptr and lock update exactly as on normal completion.
- WAIT_LO: tx_busy=0 -> IDLE, grant_valid <= 0. Completion update happens on that edge:
  - If last_q or !LOCK_ENABLE: locked <= 0 and rr_ptr <= (grant_id+1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
- Latency: handshake at cycle N, tx_enable at N+1. The earliest next handshake is the cycle after tx_busy falls.
- A byte is never launched while tx_busy=1. If tx_busy is high in IDLE (Tx still draining), no req_ready is issued.
- While locked, a deasserted owner req_valid stalls the arbiter. Other sources wait; there is no lock timeout.
- Sources must hold valid, data and last stable until ready. The block does not check this.
- tx_busy rising during LAUNCH (early Tx) is taken in WAIT_HI on the next cycle; the level is still high.
- Reset mid-operation: all state returns to reset values at the next edge. tx_enable is low after that edge; a Tx frame already started completes on its own.
- Widths: rr_ptr and grant_id are clog2(NUM_REQ) bits. Wrap-around from NUM_REQ-1 returns to 0, including for non-power-of-two NUM_REQ. The counter is clog2(BUSY_TIMEOUT)+1 bits.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, LAUNCH, WAIT_HI, WAIT_LO);
  - the clog2 width function;
  - the constant DATA_WIDTH default (8) shared with the UART top.
- One sub-module, uart_rr_pick (purely combinational): inputs valid vector, rr_ptr, lock, lock_id; outputs candidate index and found flag. It is reused by any future Rx-side scheduler.

Test Plan:
- Single byte: req_valid[0]=1, data=0xA5, last=1; Tx model raises busy 1 cycle after enable for 10 cycles. Required: req_ready[0] high 1 cycle, tx_enable one pulse next cycle with tx_data=0xA5, grant_id=0, no further ready until busy falls.
- Fairness: NUM_REQ=4, all valid continuously, last=1, LOCK_ENABLE=1. Required: grant_id sequence 0,1,2,3,0,1 and exactly one tx_enable per byte.
- Packet lock: req1 sends 0x11,0x22,0x33 (last on 0x33) while req0 and req2 are valid. Required: three consecutive req1 bytes, then req2, then req0.
- Timeout: Tx model never asserts busy, BUSY_TIMEOUT=16. Required: tx_timeout pulse 16 cycles after tx_enable, back to IDLE, the next valid source accepted and rr_ptr advanced.
- Busy at idle plus reset: hold tx_busy=1 with req_valid=4'b1111, so req_ready=0 throughout. Then assert reset during WAIT_LO. Required: next cycle grant_valid=0, tx_enable=0, and after release the first grant is id 0.
